// File: rtl/instruction_fetch.sv
// Instruction fetch front end: program counter, in-order read issue, small
// instruction FIFO and valid/ready hand-off to decode. Optional feature macro:
// INSTRUCTION_FETCH_MISALIGN_EN (sticky misaligned-redirect flag that halts fetch).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        decode_enable
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [31:0]      r_pc;
    logic [31:0]      r_fifo_word [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_discard;

    logic             w_fetch_blocked;
    logic             w_pop;
    logic [SUM_W-1:0] w_used;
    logic             w_issue;
    logic             w_outstanding;
    logic             w_rsp_drop;
    logic             w_rsp_keep;
    logic             w_push;
    logic [31:0]      w_rsp_pc;
    logic [31:0]      w_redirect_pc;

    assign w_pop = (r_count != '0) && instr_ready;

    // A head popped this cycle frees its slot immediately; without that credit a
    // single-cycle memory could only sustain two instructions every three cycles.
    assign w_used = SUM_W'(r_count) + SUM_W'(r_inflight) + SUM_W'(r_discard) - SUM_W'(w_pop);

    assign mem_req_valid = rst_n && !redirect_valid && !w_fetch_blocked
                           && (w_used < SUM_W'(FIFO_DEPTH));
    assign mem_req_addr  = r_pc;
    assign w_issue       = mem_req_valid && mem_req_ready;

    assign w_outstanding = (r_inflight != '0) || (r_discard != '0);
    assign w_rsp_drop    = mem_rsp_valid && (r_discard != '0);
    assign w_rsp_keep    = mem_rsp_valid && (r_discard == '0) && (r_inflight != '0);
    assign w_push        = w_rsp_keep && !redirect_valid;

    // Kept requests are always consecutive words ending just below r_pc, so the
    // oldest one sits r_inflight words back; no per-request address queue needed.
    assign w_rsp_pc      = r_pc - (32'(r_inflight) << 2);
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    assign instr_valid   = (r_count != '0);
    assign instruction   = r_fifo_word[r_rd_ptr];
    assign instr_pc      = r_fifo_pc[r_rd_ptr];
    assign decode_enable = w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            // NOTE: the buffer is only a few entries and its head drives the
            // instruction/instr_pc ports, which must read zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_word[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= r_discard + r_inflight - CNT_W'(mem_rsp_valid && w_outstanding);
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_fifo_word[r_wr_ptr] <= mem_rsp_data;
                r_fifo_pc[r_wr_ptr]   <= w_rsp_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_rsp_keep);
            r_discard  <= r_discard - CNT_W'(w_rsp_drop);
        end
    end

`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    logic r_misaligned;

    // Every redirect re-evaluates the flag, so an aligned one clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            r_misaligned <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_fetch_blocked  = r_misaligned;
    assign fetch_misaligned = r_misaligned;
`else
    assign w_fetch_blocked = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural memory plus an expected-address
// stream model checked every cycle, with directed scenarios and literal pins.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        decode_enable;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    logic        fetch_misaligned;
`endif

    instruction_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .decode_enable    (decode_enable)
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] cons_log[$];
    int          cons_cyc[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          lat = 1;
    logic        stall_mode = 1'b0;
    logic        prev_redir = 1'b0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the falling edge, then compare settled outputs
    // against the expected instruction stream and log accepted requests.
    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst_n          = 1'b1;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom();
        mem_req_ready  = stall_mode ? ((cyc % 3) != 1) : 1'b1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = data_of(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom();
        end
        #1;
        if (prev_redir) check("valid_after_redirect", instr_valid, 0);
        if (redir) check("no_req_in_redirect", mem_req_valid, 0);
        check("decode_enable", decode_enable, instr_valid & instr_ready);
        if (mem_req_valid) check("req_align", mem_req_addr[1:0], 0);
        if (mem_req_valid && mem_req_ready) begin
            mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
            req_log.push_back(mem_req_addr);
            req_cyc.push_back(cyc);
        end
        if (instr_valid && instr_ready) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instruction", instruction, data_of(exp_pc));
            cons_log.push_back(instr_pc);
            cons_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
        prev_redir = redir;
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_decode_enable", decode_enable, 0);
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        check("rst_misaligned", fetch_misaligned, 0);
`endif
        mem_q.delete();
        req_log.delete();
        req_cyc.delete();
        cons_log.delete();
        cons_cyc.delete();
        exp_pc     = 32'h0000_0100;
        cyc        = 0;
        prev_redir = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_consume(input string name, input int bound);
        int n0;
        int k;
        n0 = cons_log.size();
        k  = 0;
        while (cons_log.size() == n0 && k < bound) begin
            tick(1'b1, 1'b0, '0);
            k++;
        end
        check(name, cons_log.size() > n0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run not finished after 200000 ns, required finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int k;

        // Reset release and single-cycle streaming
        do_reset();
        repeat (6) tick(1'b1, 1'b0, '0);
        check("first_req_addr0", req_log[0], 32'h100);
        check("first_req_addr1", req_log[1], 32'h104);
        check("first_req_addr2", req_log[2], 32'h108);
        check("first_req_cyc2", req_cyc[2], 2);
        check("first_instr_pc", cons_log[0], 32'h100);
        check("first_instr_cyc", cons_cyc[0], 2);
        check("stream_cyc3", cons_cyc[2], 4);

        // Decode stalls: requests stop once the buffer and in-flight fill it
        repeat (10) tick(1'b0, 1'b0, '0);
        check("stall_no_req", mem_req_valid, 0);
        check("stall_valid", instr_valid, 1);
        check("stall_req_total", req_log.size(), 6);
        repeat (8) tick(1'b1, 1'b0, '0);
        check("release_count", cons_log.size(), 12);
        check("release_last_pc", cons_log[$], 32'h12C);

        // Three-cycle memory, redirect with two reads in flight
        lat = 3;
        k = 0;
        tick(1'b1, 1'b0, '0);
        while (mem_q.size() != 2 && k < 10) begin
            tick(1'b1, 1'b0, '0);
            k++;
        end
        check("two_in_flight", mem_q.size(), 2);
        tick(1'b1, 1'b1, 32'h0000_2000);
        n0 = cons_log.size();
        wait_consume("redirect_2000_timeout", 20);
        if (cons_log.size() > n0) check("redirect_first_pc", cons_log[$], 32'h2000);

        // Redirect coinciding with a response and a pop
        lat = 1;
        repeat (8) tick(1'b1, 1'b0, '0);
        n0 = cons_log.size();
        tick(1'b1, 1'b1, 32'h0000_4000);
        check("redir_pop_de", decode_enable, 1);
        check("redir_pop_count", cons_log.size(), n0 + 1);
        n0 = cons_log.size();
        wait_consume("redirect_4000_timeout", 10);
        if (cons_log.size() > n0) check("redir_4000_pc", cons_log[$], 32'h4000);
        repeat (4) tick(1'b1, 1'b0, '0);

        // Address wrap
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        req_log.delete();
        cons_log.delete();
        repeat (10) tick(1'b1, 1'b0, '0);
        check("wrap_n", cons_log.size() >= 3 && req_log.size() >= 3, 1);
        if (cons_log.size() >= 3 && req_log.size() >= 3) begin
            check("wrap_req2", req_log[2], 32'h0000_0000);
            check("wrap_pc1", cons_log[1], 32'hFFFF_FFFC);
            check("wrap_pc2", cons_log[2], 32'h0000_0000);
        end

        // Misaligned redirect
        tick(1'b1, 1'b1, 32'h0000_1002);
        req_log.delete();
        n0 = cons_log.size();
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        repeat (8) tick(1'b1, 1'b0, '0);
        check("misaligned_flag", fetch_misaligned, 1);
        check("misaligned_no_req", req_log.size(), 0);
        check("misaligned_no_instr", cons_log.size(), n0);
        tick(1'b1, 1'b1, 32'h0000_3000);
        tick(1'b1, 1'b0, '0);
        check("misaligned_clear", fetch_misaligned, 0);
        n0 = cons_log.size();
        wait_consume("resume_3000_timeout", 10);
        if (cons_log.size() > n0) check("resume_3000_pc", cons_log[$], 32'h3000);
`else
        wait_consume("misaligned_timeout", 10);
        if (cons_log.size() > n0) check("forced_align_pc", cons_log[$], 32'h1000);
        check("forced_align_req", req_log[0], 32'h1000);
`endif

        // Memory back-pressure
        stall_mode = 1'b1;
        n0 = cons_log.size();
        repeat (15) tick(1'b1, 1'b0, '0);
        stall_mode = 1'b0;
        repeat (4) tick(1'b1, 1'b0, '0);
        check("backpressure_progress", cons_log.size() > n0, 1);

        // Reset in the middle of streaming
        repeat (3) tick(1'b1, 1'b0, '0);
        do_reset();
        repeat (5) tick(1'b1, 1'b0, '0);
        check("post_reset_n", cons_log.size() > 0, 1);
        if (cons_log.size() > 0) check("post_reset_pc", cons_log[0], 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
